// File: rtl/fifo_drain_serializer.sv
// Read-side drain engine: pops full-width words from a push/pop FIFO and
// serializes each one into narrow valid/ready beats, least-significant chunk first.
module fifo_drain_serializer #(
   parameter int WIDTH     = 64,
   parameter int OUT_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 fifo_empty,
   input  logic [WIDTH-1:0]     fifo_data,
   output logic                 pop,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] word_count
);

   localparam int RATIO   = WIDTH / OUT_WIDTH;
   localparam int CHUNK_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(RATIO - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       shift_q, shift_d;
   logic [CHUNK_W-1:0]     chunk_q, chunk_d;
   logic [CNT_WIDTH-1:0]   count_q, count_d;

   logic can_pop;
   logic last_chunk;
   logic beat_accept;

   // Reset masks the pop strobe so a word is never consumed during reset.
   assign can_pop     = en & ~fifo_empty & ~rst;
   assign last_chunk  = (chunk_q == LAST_CHUNK);
   assign out_valid   = (state_q == BUSY);
   assign busy        = out_valid;
   assign out_data    = shift_q[OUT_WIDTH-1:0];
   assign out_last    = out_valid & last_chunk;
   assign beat_accept = out_valid & out_ready;
   assign word_count  = count_q;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      chunk_d = chunk_q;
      count_d = count_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (can_pop) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               chunk_d = '0;
               count_d = count_q + CNT_WIDTH'(1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (beat_accept) begin
               if (last_chunk) begin
                  // Reloading on the final accepted beat keeps words back-to-back.
                  if (can_pop) begin
                     pop     = 1'b1;
                     shift_d = fifo_data;
                     chunk_d = '0;
                     count_d = count_q + CNT_WIDTH'(1);
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  shift_d = shift_q >> OUT_WIDTH;
                  chunk_d = chunk_q + CHUNK_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         chunk_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         chunk_q <= chunk_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Scoreboard bench for fifo_drain_serializer: a 64->16 instance fed by a FIFO model,
// plus a 16->16 instance with a 4-bit word counter for the wrap and RATIO=1 cases.
module tb_fifo_drain_serializer;

   typedef enum int {R_POP, R_VALID, R_LAST, R_DATA, R_WC, R_BUSY, R_FIFOLVL, R_FLAG, R_WC2} req_kind_t;

   typedef struct {
      req_kind_t   kind;
      string       name;
      logic [63:0] value;
      logic [63:0] aux;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        en = 1'b0;
   logic        fifo_empty;
   logic [63:0] fifo_data;
   logic        pop;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;
   logic [15:0] word_count;

   logic        en2 = 1'b0;
   logic        fifo_empty2;
   logic [15:0] fifo_data2;
   logic        pop2;
   logic        out_valid2;
   logic        out_ready2 = 1'b1;
   logic [15:0] out_data2;
   logic        out_last2;
   logic        busy2;
   logic [3:0]  word_count2;

   logic [63:0] fifo_mem [0:15];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          wr2 = 0;
   int          rd2 = 0;

   logic [63:0] wexp[$];
   logic [15:0] w2exp[$];
   req_t        req_q[$];

   int          errors = 0;
   int          checks = 0;
   int          beat_idx = 0;

   always #5 clk = ~clk;

   fifo_drain_serializer #(.WIDTH(64), .OUT_WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .pop(pop), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .word_count(word_count)
   );

   fifo_drain_serializer #(.WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(4)) dut2 (
      .clk(clk), .rst(rst), .en(en2), .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
      .pop(pop2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .out_last(out_last2), .busy(busy2), .word_count(word_count2)
   );

   // FIFO models: head word is visible combinationally, pop advances on the edge
   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_data   = fifo_mem[rd_ptr % 16];
   assign fifo_empty2 = (wr2 == rd2);
   assign fifo_data2  = {4'hA, rd2[11:0]};

   always @(posedge clk) begin
      if (pop)  rd_ptr <= rd_ptr + 1;
      if (pop2) rd2    <= rd2 + 1;
   end

   function automatic void checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endfunction

   // Monitor: sole owner of the counters; compares beats and queued point checks
   always @(negedge clk) begin
      logic [63:0] w;
      if (pop)  checkOutput("pop_while_empty", 64'(fifo_empty), 64'd0);
      if (pop2) checkOutput("pop2_while_empty", 64'(fifo_empty2), 64'd0);
      if (pop && out_valid) checkOutput("pop_only_on_last_accept", 64'(out_last & out_ready), 64'd1);
      if (rst) begin
         if (beat_idx != 0 && wexp.size() != 0) wexp.delete(0);
         beat_idx = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (wexp.size() == 0) begin
               checkOutput("unexpected_beat", 64'(wexp.size()), 64'd1);
            end else begin
               w = wexp[0];
               checkOutput("beat_data", 64'(out_data), 64'(w[beat_idx*16 +: 16]));
               checkOutput("beat_last", 64'(out_last), 64'(beat_idx == 3));
               checkOutput("beat_busy", 64'(busy), 64'd1);
               beat_idx++;
               if (beat_idx == 4) begin
                  wexp.delete(0);
                  beat_idx = 0;
               end
            end
         end
         if (out_valid2 && out_ready2) begin
            if (w2exp.size() == 0) begin
               checkOutput("dut2_unexpected_beat", 64'(w2exp.size()), 64'd1);
            end else begin
               checkOutput("dut2_beat_data", 64'(out_data2), 64'(w2exp[0]));
               checkOutput("dut2_beat_last", 64'(out_last2), 64'd1);
               w2exp.delete(0);
            end
         end
      end
      while (req_q.size() != 0) begin
         req_t r;
         r = req_q.pop_front();
         case (r.kind)
            R_POP:     checkOutput(r.name, 64'(pop), r.value);
            R_VALID:   checkOutput(r.name, 64'(out_valid), r.value);
            R_LAST:    checkOutput(r.name, 64'(out_last), r.value);
            R_DATA:    checkOutput(r.name, 64'(out_data), r.value);
            R_WC:      checkOutput(r.name, 64'(word_count), r.value);
            R_BUSY:    checkOutput(r.name, 64'(busy), r.value);
            R_FIFOLVL: checkOutput(r.name, 64'(wr_ptr - rd_ptr), r.value);
            R_WC2:     checkOutput(r.name, 64'(word_count2), r.value);
            default:   checkOutput(r.name, r.aux, r.value);
         endcase
      end
   end

   task automatic expectNow(input req_kind_t k, input string n, input logic [63:0] v, input logic [63:0] a = 64'd0);
      req_t r;
      r.kind  = k;
      r.name  = n;
      r.value = v;
      r.aux   = a;
      req_q.push_back(r);
   endtask

   task automatic applyStimulus(input logic [63:0] word);
      fifo_mem[wr_ptr % 16] = word;
      wr_ptr++;
      wexp.push_back(word);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
   endtask

   task automatic waitDrain(input string n, input int budget);
      int cyc = 0;
      while ((wexp.size() != 0 || out_valid) && cyc < budget) begin
         nextCycle();
         cyc++;
      end
      expectNow(R_FLAG, n, 64'd1, 64'(cyc < budget));
   endtask

   initial begin
      nextCycle();
      nextCycle();
      rst = 1'b0;
      $display("[TB] reset state");
      expectNow(R_VALID, "rst_valid", 64'd0);
      expectNow(R_LAST,  "rst_last",  64'd0);
      expectNow(R_BUSY,  "rst_busy",  64'd0);
      expectNow(R_DATA,  "rst_data",  64'd0);
      expectNow(R_WC,    "rst_wc",    64'd0);
      expectNow(R_POP,   "rst_pop",   64'd0);

      $display("[TB] single word");
      applyStimulus(64'h4444_3333_2222_1111);
      nextCycle();
      en = 1'b1;
      expectNow(R_POP, "t1_pop", 64'd1);
      for (int i = 0; i < 4; i++) begin
         nextCycle();
         expectNow(R_VALID, "t1_valid", 64'd1);
         expectNow(R_LAST,  "t1_last",  64'(i == 3));
         expectNow(R_POP,   "t1_no_pop", 64'd0);
      end
      nextCycle();
      expectNow(R_VALID, "t1_idle", 64'd0);
      expectNow(R_WC,    "t1_wc",   64'd1);
      en = 1'b0;

      $display("[TB] back-to-back words");
      resetDut();
      applyStimulus(64'h8888_7777_6666_5555);
      applyStimulus(64'hDDDD_CCCC_BBBB_AAAA);
      en = 1'b1;
      expectNow(R_POP, "t2_pop_first", 64'd1);
      for (int i = 0; i < 8; i++) begin
         nextCycle();
         expectNow(R_VALID, "t2_no_bubble", 64'd1);
         expectNow(R_POP,   "t2_pop_on_last", 64'(i == 3));
      end
      nextCycle();
      en = 1'b0;
      expectNow(R_VALID, "t2_idle", 64'd0);
      expectNow(R_WC,    "t2_wc",   64'd2);

      $display("[TB] backpressure");
      resetDut();
      applyStimulus(64'h4444_3333_2222_1111);
      en = 1'b1;
      nextCycle();
      en = 1'b0;
      nextCycle();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expectNow(R_DATA,  "t3_hold_data",  64'h2222);
         expectNow(R_VALID, "t3_hold_valid", 64'd1);
         expectNow(R_LAST,  "t3_hold_last",  64'd0);
         nextCycle();
      end
      out_ready = 1'b1;
      waitDrain("t3_drain_timeout", 20);
      expectNow(R_WC, "t3_wc", 64'd1);

      $display("[TB] enable dropped mid-word");
      resetDut();
      applyStimulus(64'h0A0A_0B0B_0C0C_0D0D);
      applyStimulus(64'h1357_2468_9BDF_ACE0);
      en = 1'b1;
      expectNow(R_POP, "t4_pop", 64'd1);
      nextCycle();
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expectNow(R_POP, "t4_no_second_pop", 64'd0);
         nextCycle();
      end
      expectNow(R_VALID,   "t4_idle",       64'd0);
      expectNow(R_FIFOLVL, "t4_fifo_level", 64'd1);
      expectNow(R_WC,      "t4_wc",         64'd1);
      en = 1'b1;
      expectNow(R_POP, "t4_repop", 64'd1);
      nextCycle();
      en = 1'b0;
      waitDrain("t4_drain_timeout", 20);

      $display("[TB] reset mid-word");
      resetDut();
      out_ready = 1'b0;
      applyStimulus(64'hFFFF_EEEE_9999_1234);
      applyStimulus(64'h0004_0003_0002_0001);
      en = 1'b1;
      expectNow(R_POP, "t5_pop", 64'd1);
      nextCycle();
      out_ready = 1'b1;
      nextCycle();
      nextCycle();
      out_ready = 1'b0;
      rst = 1'b1;
      expectNow(R_POP, "t5_pop_in_rst_busy", 64'd0);
      nextCycle();
      expectNow(R_POP,   "t5_pop_in_rst_idle", 64'd0);
      expectNow(R_VALID, "t5_valid_after_rst", 64'd0);
      expectNow(R_WC,    "t5_wc_after_rst",    64'd0);
      nextCycle();
      rst = 1'b0;
      out_ready = 1'b1;
      expectNow(R_POP, "t5_pop_next_word", 64'd1);
      nextCycle();
      en = 1'b0;
      waitDrain("t5_drain_timeout", 20);
      expectNow(R_WC,      "t5_wc",         64'd1);
      expectNow(R_FIFOLVL, "t5_fifo_level", 64'd0);

      $display("[TB] empty fifo");
      resetDut();
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         expectNow(R_POP,   "t6_pop_empty",   64'd0);
         expectNow(R_VALID, "t6_valid_empty", 64'd0);
         nextCycle();
      end
      en = 1'b0;

      $display("[TB] counter wrap, ratio 1");
      for (int k = 0; k < 17; k++) w2exp.push_back({4'hA, 12'(k)});
      wr2 = 17;
      en2 = 1'b1;
      begin
         int cyc = 0;
         while ((w2exp.size() != 0 || out_valid2) && cyc < 60) begin
            nextCycle();
            cyc++;
         end
         expectNow(R_FLAG, "t7_drain_timeout", 64'd1, 64'(cyc < 60));
      end
      en2 = 1'b0;
      expectNow(R_WC2, "t7_wc_wrap", 64'd1);
      expectNow(R_FLAG, "scoreboard_empty", 64'd0, 64'(wexp.size() + w2exp.size()));
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
